lever_bank: RTL and testbench

LEVER_BANK -- requirements
Module: lever_bank

---
 rtl/lever_bank_pkg.sv | 23 ++
 rtl/lever_bank_pulse.sv | 31 +++
 rtl/lever_bank.sv | 129 ++++++++++++
 tb/tb_lever_bank.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lever_bank_pkg.sv
// Shared definitions for the lever bank controller: FSM state codes,
// ball colour encoding and the exit counter ceiling.
package lever_bank_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t PULSE = 2'd1;
  localparam state_t ARMED = 2'd2;
  localparam state_t HALT  = 2'd3;

  // Colour encoding matches the board's current_color signal.
  localparam logic BLUE = 1'b0;
  localparam logic RED  = 1'b1;

  localparam logic [5:0] EXIT_COUNT_MAX = 6'd63;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [5:0] sat_inc(input logic [5:0] value);
    return (value == EXIT_COUNT_MAX) ? value : value + 6'd1;
  endfunction

endpackage

// File: rtl/lever_bank_pulse.sv
// Loadable down-counter that shapes the trigger strobe. A load makes the
// strobe rise on the next cycle and stay high for PULSE_LEN cycles; done
// marks the final strobe cycle so the FSM can leave PULSE on that edge.
module lever_pulse #(
  parameter int PULSE_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic strobe,
  output logic done,
  output logic idle
);

  logic [3:0] cnt;

  // Count down from PULSE_LEN to zero after each load.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 4'd0;
    else if (load)
      cnt <= 4'(PULSE_LEN);
    else if (cnt != 4'd0)
      cnt <= cnt - 4'd1;
  end

  assign strobe = (cnt != 4'd0);
  assign done   = (cnt == 4'd1);
  assign idle   = (cnt == 4'd0);

endmodule

// File: rtl/lever_bank.sv
// Lever bank controller: releases balls of the requested colour, waits for
// the ball to leave through a lever, re-triggers with the exit colour and
// halts on interception, empty supply or a missing exit.
module lever_bank
  import lever_bank_pkg::*;
#(
  parameter int PULSE_LEN = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       start_red,
  input  logic       ball_left,
  input  logic       ball_right,
  input  logic       ball_intercept,
  input  logic       no_balls,
  output logic       blue_trigger,
  output logic       red_trigger,
  output logic       busy,
  output logic       halted,
  output logic       timeout,
  output logic       collision,
  output logic [5:0] exit_count
);

  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

  state_t      state;
  logic        colour;
  logic [15:0] wait_cnt;
  logic        pulse_load;
  logic        pulse_strobe;
  logic        pulse_done;
  logic        pulse_idle;
  logic [1:0]  exit_hits;
  logic        any_exit;
  logic        multi_exit;

  assign exit_hits  = 2'(ball_left) + 2'(ball_right) + 2'(ball_intercept);
  assign any_exit   = (exit_hits != 2'd0);
  assign multi_exit = (exit_hits >= 2'd2);

  // The strobe counter is idle on the first PULSE cycle only, so that is
  // where it gets loaded; the strobe therefore starts one cycle after entry.
  assign pulse_load = (state == PULSE) && pulse_idle;

  lever_pulse #(
    .PULSE_LEN(PULSE_LEN)
  ) u_pulse (
    .clk   (clk),
    .rst   (rst),
    .load  (pulse_load),
    .strobe(pulse_strobe),
    .done  (pulse_done),
    .idle  (pulse_idle)
  );

  assign blue_trigger = pulse_strobe && (colour == BLUE);
  assign red_trigger  = pulse_strobe && (colour == RED);
  assign busy         = (state == PULSE) || (state == ARMED);
  assign halted       = (state == HALT);

  // Main sequencer: state, latched colour, wait counter and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      colour     <= BLUE;
      wait_cnt   <= 16'd0;
      timeout    <= 1'b0;
      collision  <= 1'b0;
      exit_count <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_exit)
            collision <= 1'b1;
          if (start) begin
            state  <= PULSE;
            colour <= start_red;
          end
        end
        PULSE: begin
          if (any_exit)
            collision <= 1'b1;
          if (pulse_done) begin
            state    <= ARMED;
            wait_cnt <= 16'd0;
          end
        end
        ARMED: begin
          if (multi_exit)
            collision <= 1'b1;
          if (ball_intercept) begin
            state <= HALT;
          end else if (ball_left) begin
            exit_count <= sat_inc(exit_count);
            colour     <= BLUE;
            state      <= PULSE;
          end else if (ball_right) begin
            exit_count <= sat_inc(exit_count);
            colour     <= RED;
            state      <= PULSE;
          end else if (no_balls && (wait_cnt == 16'd0)) begin
            state <= HALT;
          end else if (wait_cnt == WAIT_LIMIT) begin
            timeout <= 1'b1;
            state   <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        HALT: begin
          if (start) begin
            exit_count <= 6'd0;
            timeout    <= 1'b0;
            collision  <= 1'b0;
            colour     <= start_red;
            state      <= PULSE;
          end else if (any_exit) begin
            collision <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lever_bank.sv
// Scoreboard bench for lever_bank: the driver updates a transaction-level
// model and queues the trigger pulses it expects; a monitor pops and checks
// each pulse the DUT produces.
module tb_lever_bank;

  localparam int PL = 2;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start_red = 1'b0;
  logic       ball_left = 1'b0;
  logic       ball_right = 1'b0;
  logic       ball_intercept = 1'b0;
  logic       no_balls = 1'b0;
  logic       blue_trigger;
  logic       red_trigger;
  logic       busy;
  logic       halted;
  logic       timeout;
  logic       collision;
  logic [5:0] exit_count;

  typedef struct {
    bit red;
    int count;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t exp_p;
  int     checks_total = 0;
  int     checks_passed = 0;

  int m_count = 0;
  bit m_timeout = 0;
  bit m_collision = 0;
  bit m_halted = 0;
  bit m_busy = 0;
  bit abort_pulse = 0;

  bit mon_in_pulse = 0;
  int mon_width = 0;

  lever_bank #(
    .PULSE_LEN(PL),
    .TIMEOUT  (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_red     (start_red),
    .ball_left     (ball_left),
    .ball_right    (ball_right),
    .ball_intercept(ball_intercept),
    .no_balls      (no_balls),
    .blue_trigger  (blue_trigger),
    .red_trigger   (red_trigger),
    .busy          (busy),
    .halted        (halted),
    .timeout       (timeout),
    .collision     (collision),
    .exit_count    (exit_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One cycle of input drive; values are sampled on the following rising edge.
  task automatic applyStimulus(input bit s, input bit sr, input bit l, input bit r,
                               input bit i, input bit nb);
    @(negedge clk);
    start          = s;
    start_red      = sr;
    ball_left      = l;
    ball_right     = r;
    ball_intercept = i;
    no_balls       = nb;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  // Spends one quiet cycle and compares the status outputs with the model.
  task automatic checkStatus(input string tag);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput({tag, "_halted"}, int'(halted), int'(m_halted));
    checkOutput({tag, "_busy"}, int'(busy), int'(m_busy));
    checkOutput({tag, "_timeout"}, int'(timeout), int'(m_timeout));
    checkOutput({tag, "_collision"}, int'(collision), int'(m_collision));
    checkOutput({tag, "_exit_count"}, int'(exit_count), m_count);
  endtask

  // Start a run from IDLE or HALT; returns in the first armed cycle slot.
  task automatic opStart(input bit red);
    if (m_halted) begin
      m_count     = 0;
      m_timeout   = 0;
      m_collision = 0;
    end
    m_halted = 0;
    m_busy   = 1;
    exp_q.push_back('{red: red, count: m_count});
    applyStimulus(1, red, 0, 0, 0, 0);
    idleCycles(PL + 1);
  endtask

  // Wait k armed cycles, then a ball exits; optionally a stray exit during the pulse.
  task automatic opExit(input bit right, input int k, input bit spur);
    int spur_at;
    idleCycles(k);
    if (m_count < 63)
      m_count++;
    exp_q.push_back('{red: right, count: m_count});
    applyStimulus(0, 0, !right, right, 0, 0);
    spur_at = spur ? int'($urandom_range(0, PL)) : -1;
    for (int c = 0; c <= PL; c++) begin
      if (c == spur_at) begin
        m_collision = 1;
        applyStimulus(0, 0, 1, 0, 0, 0);
      end else begin
        applyStimulus(0, 0, 0, 0, 0, 0);
      end
    end
  endtask

  task automatic opIntercept(input bit with_left, input int k);
    idleCycles(k);
    if (with_left)
      m_collision = 1;
    m_halted = 1;
    m_busy   = 0;
    applyStimulus(0, 0, with_left, 0, 1, 0);
  endtask

  task automatic opNoBalls();
    m_halted = 1;
    m_busy   = 0;
    applyStimulus(0, 0, 0, 0, 0, 1);
  endtask

  task automatic opTimeout();
    idleCycles(TO);
    m_timeout = 1;
    m_halted  = 1;
    m_busy    = 0;
  endtask

  // Monitor: pop an expectation at every trigger rising edge, check width at its fall.
  always @(negedge clk) begin
    if (blue_trigger || red_trigger) begin
      checkOutput("trigger_overlap", int'(blue_trigger && red_trigger), 0);
      if (!mon_in_pulse) begin
        mon_in_pulse = 1;
        mon_width    = 1;
        checkOutput("pulse_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_p = exp_q.pop_front();
          checkOutput("pulse_red", int'(red_trigger), int'(exp_p.red));
          checkOutput("pulse_exit_count", int'(exit_count), exp_p.count);
        end
      end else begin
        mon_width++;
      end
    end else if (mon_in_pulse) begin
      mon_in_pulse = 0;
      if (!abort_pulse)
        checkOutput("pulse_width", mon_width, PL);
    end
  end

  initial begin
    int n;
    bit red;

    // Reset state.
    idleCycles(2);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_blue_trigger", int'(blue_trigger), 0);
    checkOutput("reset_red_trigger", int'(red_trigger), 0);
    checkStatus("reset");

    // Blue start, then right and left exits with a start ignored while armed.
    opStart(0);
    idleCycles(2);
    applyStimulus(1, 1, 0, 0, 0, 0);
    opExit(1, 1, 0);
    checkOutput("after_right_count", int'(exit_count), 1);
    opExit(0, 0, 0);
    checkStatus("two_exits");

    // Left and intercept together: halt, collision, count unchanged, no trigger.
    opIntercept(1, 2);
    idleCycles(6);
    checkStatus("intercept_collision");

    // Exit just before the timeout limit, then a real timeout and a restart.
    opStart(1);
    opExit(0, TO - 2, 0);
    checkStatus("late_exit");
    opTimeout();
    checkStatus("timeout");
    opStart(0);
    checkStatus("restart_after_timeout");

    // Randomised runs.
    opIntercept(0, 3);
    for (int run = 0; run < 6; run++) begin
      red = 1'($urandom_range(0, 1));
      opStart(red);
      n = int'($urandom_range(3, 10));
      for (int e = 0; e < n; e++)
        opExit(1'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
               $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0)
        opIntercept(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)));
      else
        opNoBalls();
      checkStatus("random_run");
    end

    // Exit counter saturation.
    opStart(0);
    for (int e = 0; e < 64; e++)
      opExit(0, 0, 0);
    checkStatus("saturation");

    // Empty supply halts right after the pulse; an exit while halted is a collision.
    opIntercept(0, 1);
    opStart(1);
    opNoBalls();
    idleCycles(8);
    checkStatus("no_balls");
    m_collision = 1;
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkStatus("exit_in_halt");

    // Reset during the first trigger cycle.
    abort_pulse = 1;
    m_count = 0;
    m_timeout = 0;
    m_collision = 0;
    m_halted = 0;
    m_busy = 1;
    exp_q.push_back('{red: 1'b0, count: 0});
    applyStimulus(1, 0, 0, 0, 0, 0);
    idleCycles(1);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_busy = 0;
    checkOutput("midpulse_blue_trigger", int'(blue_trigger), 0);
    checkOutput("midpulse_red_trigger", int'(red_trigger), 0);
    checkStatus("midpulse_reset");
    idleCycles(6);
    checkOutput("midpulse_no_resume", int'(blue_trigger || red_trigger), 0);
    abort_pulse = 0;

    checkOutput("pulses_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
